// File: rtl/temp_pkg.sv
// Constants and types shared by the temperature conditioning stage and the
// downstream state machine, so the in-range thresholds stay identical.
package temp_pkg;

    localparam int unsigned W_ADC  = 12;
    localparam int unsigned W_TEMP = 11;
    localparam int unsigned W_SUM  = 13;
    localparam int unsigned W_CNT  = 3;

    localparam logic signed [W_TEMP-1:0] TEMP_BAJO = 11'sd180;
    localparam logic signed [W_TEMP-1:0] TEMP_ALTO = 11'sd259;
    localparam logic [W_CNT-1:0]         CNT_MAX   = 3'd7;

    typedef enum logic [1:0] {ESPERA, ACTIVO, FALLA} estado_acond_t;

    // Clamp a converted 13-bit code to the signed 11-bit temperature range.
    function automatic logic [W_TEMP-1:0] saturar(input logic signed [W_SUM-1:0] x);
        if (x > 13'sd1023) begin
            return 11'h3FF;
        end else if (x < -13'sd1024) begin
            return 11'h400;
        end else begin
            return x[W_TEMP-1:0];
        end
    endfunction

endpackage

// File: rtl/promedio_movil.sv
// 4-tap moving average with running sum; prefill loads every tap with the
// incoming sample so the first average equals that sample.
module promedio_movil
    import temp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              prefill,
    input  logic [W_TEMP-1:0] dato,
    output logic [W_TEMP-1:0] promedio_c
);

    logic [3:0][W_TEMP-1:0] taps;
    logic signed [W_SUM-1:0] suma;
    logic signed [W_SUM-1:0] suma_sig;
    logic signed [W_SUM-1:0] dato_ext;
    logic signed [W_SUM-1:0] viejo_ext;

    always_comb begin
        dato_ext  = $signed({{(W_SUM-W_TEMP){dato[W_TEMP-1]}}, dato});
        viejo_ext = $signed({{(W_SUM-W_TEMP){taps[3][W_TEMP-1]}}, taps[3]});
        if (prefill) begin
            suma_sig = $signed({dato_ext[W_SUM-3:0], 2'b00});
        end else begin
            suma_sig = suma + dato_ext - viejo_ext;
        end
    end

    // Dropping the two LSBs of the signed sum is the arithmetic shift by 2.
    assign promedio_c = suma_sig[W_SUM-1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            taps <= '0;
            suma <= '0;
        end else if (valid) begin
            suma <= suma_sig;
            if (prefill) begin
                taps <= {4{dato}};
            end else begin
                taps <= {taps[2:0], dato};
            end
        end
    end

endmodule

// File: rtl/acondiciona_temp.sv
// Converts raw ADC codes to saturated 0.1 C temperature, filters them, tracks
// out-of-range persistence and flags a sensor that stops sending samples.
module acondiciona_temp
    import temp_pkg::*;
#(
    parameter int unsigned OFFSET_ADC     = 1024,
    parameter int          TEMP_RESET     = 220,
    parameter int unsigned TIMEOUT_CICLOS = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adc_valid,
    input  logic [W_ADC-1:0]  adc_dato,
    output logic [W_TEMP-1:0] temp_registrado,
    output logic              temp_valido,
    output logic [W_CNT-1:0]  contador_fuera_rango,
    output logic              sensor_falla
);

    localparam int unsigned W_TO = $clog2(TIMEOUT_CICLOS);
    localparam logic [W_TO-1:0] LIM_TO = W_TO'(TIMEOUT_CICLOS - 1);

    estado_acond_t estado, estado_sig;
    logic [W_TO-1:0] cnt_to, cnt_to_sig;

    logic signed [W_SUM-1:0] t_conv_c;
    logic                    s1_valid;
    logic                    s1_prefill;
    logic [W_TEMP-1:0]       s1_dato;

    logic signed [W_TEMP-1:0] promedio_c;
    logic                     lado_alto, lado_alto_sig;
    logic [W_CNT-1:0]         contador_sig;

    assign t_conv_c = $signed({1'b0, adc_dato}) - $signed(W_SUM'(OFFSET_ADC));

    // Sensor supervision: a sample always wins over an expiring timeout.
    always_comb begin
        estado_sig = estado;
        cnt_to_sig = '0;
        case (estado)
            ESPERA: if (adc_valid) estado_sig = ACTIVO;
            ACTIVO: begin
                if (!adc_valid) begin
                    if (cnt_to == LIM_TO) begin
                        estado_sig = FALLA;
                    end else begin
                        cnt_to_sig = cnt_to + 1'b1;
                    end
                end
            end
            FALLA:  if (adc_valid) estado_sig = ACTIVO;
            default: estado_sig = ESPERA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado       <= ESPERA;
            cnt_to       <= '0;
            sensor_falla <= 1'b0;
        end else begin
            estado       <= estado_sig;
            cnt_to       <= cnt_to_sig;
            sensor_falla <= (estado_sig == FALLA);
        end
    end

    // Stage 1: saturated conversion; window prefill whenever not yet active.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_prefill <= 1'b0;
            s1_dato    <= '0;
        end else begin
            s1_valid <= adc_valid;
            if (adc_valid) begin
                s1_dato    <= saturar(t_conv_c);
                s1_prefill <= (estado != ACTIVO);
            end
        end
    end

    promedio_movil u_promedio (
        .clk        (clk),
        .rst        (rst),
        .valid      (s1_valid),
        .prefill    (s1_prefill),
        .dato       (s1_dato),
        .promedio_c (promedio_c)
    );

    // Persistence: count restarts whenever the out-of-range side changes.
    always_comb begin
        contador_sig  = '0;
        lado_alto_sig = lado_alto;
        if (promedio_c < TEMP_BAJO) begin
            lado_alto_sig = 1'b0;
            if (contador_fuera_rango != '0 && !lado_alto) begin
                contador_sig = (contador_fuera_rango == CNT_MAX) ? CNT_MAX
                                                                 : contador_fuera_rango + 1'b1;
            end else begin
                contador_sig = 3'd1;
            end
        end else if (promedio_c > TEMP_ALTO) begin
            lado_alto_sig = 1'b1;
            if (contador_fuera_rango != '0 && lado_alto) begin
                contador_sig = (contador_fuera_rango == CNT_MAX) ? CNT_MAX
                                                                 : contador_fuera_rango + 1'b1;
            end else begin
                contador_sig = 3'd1;
            end
        end
    end

    // Stage 2: filtered output and persistence count registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            temp_registrado      <= W_TEMP'(TEMP_RESET);
            contador_fuera_rango <= '0;
            temp_valido          <= 1'b0;
            lado_alto            <= 1'b0;
        end else begin
            temp_valido <= s1_valid;
            if (s1_valid) begin
                temp_registrado      <= promedio_c;
                contador_fuera_rango <= contador_sig;
                lado_alto            <= lado_alto_sig;
            end
        end
    end

endmodule

// File: tb/tb_acondiciona_temp.sv
// Directed bench for acondiciona_temp: expected outputs are queued at issue
// time and checked by a monitor whenever temp_valido pulses.
module tb_acondiciona_temp;

    logic        clk = 1'b0;
    logic        rst;
    logic        adc_valid;
    logic [11:0] adc_dato;
    logic [10:0] temp_registrado;
    logic        temp_valido;
    logic [2:0]  contador_fuera_rango;
    logic        sensor_falla;

    typedef struct packed {
        logic signed [10:0] t;
        logic [2:0]         c;
    } esperado_t;

    esperado_t cola[$];
    int n_chk  = 0;
    int n_fail = 0;

    acondiciona_temp dut (
        .clk                  (clk),
        .rst                  (rst),
        .adc_valid            (adc_valid),
        .adc_dato             (adc_dato),
        .temp_registrado      (temp_registrado),
        .temp_valido          (temp_valido),
        .contador_fuera_rango (contador_fuera_rango),
        .sensor_falla         (sensor_falla)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nombre, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nombre, act, req, $time);
        end
    endtask

    task automatic esperar(input int t, input int c);
        esperado_t e;
        e.t = 11'(t);
        e.c = 3'(c);
        cola.push_back(e);
    endtask

    task automatic enviar(input int d);
        @(negedge clk);
        adc_valid = 1'b1;
        adc_dato  = 12'(d);
    endtask

    task automatic ocioso(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            adc_valid = 1'b0;
        end
    endtask

    task automatic reiniciar();
        @(negedge clk);
        rst       = 1'b1;
        adc_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reposo(input string nombre);
        chk({nombre, "_temp"}, int'($signed(temp_registrado)), 220);
        chk({nombre, "_cnt"}, int'(contador_fuera_rango), 0);
        chk({nombre, "_valido"}, int'(temp_valido), 0);
        chk({nombre, "_falla"}, int'(sensor_falla), 0);
    endtask

    // Monitor: every temp_valido pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (temp_valido) begin
            if (cola.size() == 0) begin
                chk("pulso_inesperado", int'($signed(temp_registrado)), -9999);
            end else begin
                esperado_t e;
                e = cola.pop_front();
                chk("temp", int'($signed(temp_registrado)), int'(e.t));
                chk("contador", int'(contador_fuera_rango), int'(e.c));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        adc_valid = 1'b0;
        adc_dato  = '0;
        repeat (2) @(negedge clk);
        chk_reposo("reset");
        rst = 1'b0;

        // ESPERA never times out
        ocioso(1100);
        chk("espera_sin_falla", int'(sensor_falla), 0);

        // 1: single sample, exact pass-through
        enviar(1244); esperar(220, 0);
        ocioso(4);

        // 2: saturation high, then low, with side changes
        reiniciar();
        enviar(4095); esperar(1023, 1);
        enviar(0);    esperar(511, 2);
        enviar(0);    esperar(-1, 1);
        enviar(0);    esperar(-513, 2);
        enviar(0);    esperar(-1024, 3);
        ocioso(4);

        // 3: filter ramp
        reiniciar();
        enviar(1244); esperar(220, 0);
        enviar(1324); esperar(240, 0);
        enviar(1324); esperar(260, 1);
        enviar(1324); esperar(280, 2);
        enviar(1324); esperar(300, 3);
        ocioso(4);

        // 4: persistence saturation, then recovery and high side
        reiniciar();
        for (int i = 0; i < 10; i++) begin
            enviar(1100);
            esperar(76, (i < 7) ? i + 1 : 7);
        end
        enviar(1400); esperar(151, 7);
        enviar(1400); esperar(226, 0);
        enviar(1400); esperar(301, 1);
        enviar(1400); esperar(376, 2);
        ocioso(4);

        // 5: sample on expiry cycle prevents FALLA, then a real timeout
        reiniciar();
        enviar(1244); esperar(220, 0);
        ocioso(999);
        enviar(1300); esperar(234, 0);
        ocioso(1);
        chk("expira_con_muestra", int'(sensor_falla), 0);
        ocioso(999);
        chk("falla_antes", int'(sensor_falla), 0);
        ocioso(1);
        chk("falla", int'(sensor_falla), 1);
        chk("falla_temp_retenida", int'($signed(temp_registrado)), 234);
        chk("falla_cnt_retenido", int'(contador_fuera_rango), 0);
        ocioso(20);
        chk("falla_sigue", int'(sensor_falla), 1);
        enviar(1250); esperar(226, 0);
        ocioso(1);
        chk("falla_despeja", int'(sensor_falla), 0);
        ocioso(4);

        // 6: reset with a sample in flight discards it
        reiniciar();
        enviar(1300); esperar(276, 1);
        enviar(1300);
        @(negedge clk);
        rst       = 1'b1;
        adc_valid = 1'b0;
        @(negedge clk);
        chk_reposo("reset_vuelo");
        rst = 1'b0;
        ocioso(6);

        chk("pendientes", cola.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
